// File: rtl/vector_pe_multi_if.sv
// vector_pe_multi_if: issue-side bus for the packed-SIMD processing element.
// Carries the start/done handshake, op/sew selection, packed operands and result.
interface vector_pe_multi_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3
);
    logic              start;
    logic [OP_W-1:0]   op;
    logic [9:0]        sew;
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic [DATA_W-1:0] opC;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] peout;

    // Issue logic drives requests and observes status/results.
    modport master (
        output start, op, sew, opA, opB, opC,
        input  busy, done, err, peout
    );

    // Processing element consumes requests and produces status/results.
    modport slave (
        input  start, op, sew, opA, opB, opC,
        output busy, done, err, peout
    );
endinterface

// File: rtl/vector_pe_multi.sv
// vector_pe_multi: packed-SIMD integer PE (ADD/SUB/MUL/MACC) on SEW = 8/16/32
// elements, with a per-element MSB-first bit-serial signed multiplier.
// Optional feature macro VPE_SATURATE_EN: ADD, SUB and the final MACC
// addition saturate per element; without it they wrap modulo 2^SEW.
module vector_pe_multi #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3
) (
    input logic                clk,
    input logic                reset,
    vector_pe_multi_if.slave   bus
);

    localparam int N8  = DATA_W / 8;
    localparam int N16 = DATA_W / 16;
    localparam int N32 = DATA_W / 32;

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_MACC = OP_W'(3);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL      = 2'd1,
        S_COMPLETE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [9:0]        sew_q, sew_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] c_q, c_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] peout_q, peout_d;
    logic [5:0]        cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mul_nx;
    logic [DATA_W-1:0] addsub_res;
    logic [DATA_W-1:0] macc_res;
    logic [31:0]       lane_t;
    logic              first;
    logic              is_sub;

    function automatic logic legal_sew(input logic [9:0] s);
        return ((s == 10'd8) || (s == 10'd16) || (s == 10'd32)) &&
               ({22'd0, s} <= 32'(DATA_W));
    endfunction

    function automatic logic legal_op(input logic [OP_W-1:0] o);
        return 32'(o) < 32'd4;
    endfunction

    function automatic logic [31:0] lane_mask(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // One multiplier iteration on a lane held in the low bits of a 32-bit word;
    // only the low lane-width bits of the result are meaningful (mod 2^SEW).
    function automatic logic [31:0] mul_step(input logic [31:0] acc,
                                             input logic [31:0] a,
                                             input logic        bit_b,
                                             input logic        first_it);
        logic [31:0] addend;
        addend = bit_b ? a : 32'd0;
        if (first_it) return 32'd0 - addend;
        return (acc << 1) + addend;
    endfunction

`ifdef VPE_SATURATE_EN
    // Clamp a lane-width add/sub result to the signed lane range on overflow.
    function automatic logic [31:0] sat_lane(input logic [31:0] r,
                                             input logic [31:0] x,
                                             input logic [31:0] y,
                                             input logic        sub,
                                             input int unsigned w);
        logic xs, ys, rs, ovf;
        xs  = x[w-1];
        ys  = y[w-1];
        rs  = r[w-1];
        ovf = sub ? ((xs != ys) && (rs != xs)) : ((xs == ys) && (rs != xs));
        if (!ovf) return r;
        return xs ? (32'd1 << (w - 1)) : ((32'd1 << (w - 1)) - 32'd1);
    endfunction
`endif

    // Lane add/sub on zero-extended lane values; upper bits are cleared.
    function automatic logic [31:0] lane_addsub(input logic [31:0] x,
                                                input logic [31:0] y,
                                                input logic        sub,
                                                input int unsigned w);
        logic [31:0] r;
        r = sub ? (x - y) : (x + y);
`ifdef VPE_SATURATE_EN
        r = sat_lane(r, x, y, sub, w);
`endif
        return r & lane_mask(w);
    endfunction

    assign bus.busy  = (state_q != S_IDLE);
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.peout = peout_q;

    assign first  = (cnt_q == sew_q[5:0]);
    assign is_sub = (op_q == OP_SUB);

    // Per-element datapath: multiplier step, add/sub and MACC final add for the latched SEW.
    always_comb begin
        mul_nx     = acc_q;
        addsub_res = '0;
        macc_res   = '0;
        lane_t     = '0;
        case (sew_q)
            10'd8: begin
                for (int e = 0; e < N8; e++) begin
                    lane_t = mul_step({24'd0, acc_q[e*8 +: 8]}, {24'd0, a_q[e*8 +: 8]},
                                      b_q[e*8 + 7], first);
                    mul_nx[e*8 +: 8] = lane_t[7:0];
                    lane_t = lane_addsub({24'd0, a_q[e*8 +: 8]}, {24'd0, b_q[e*8 +: 8]}, is_sub, 8);
                    addsub_res[e*8 +: 8] = lane_t[7:0];
                    lane_t = lane_addsub({24'd0, acc_q[e*8 +: 8]}, {24'd0, c_q[e*8 +: 8]}, 1'b0, 8);
                    macc_res[e*8 +: 8] = lane_t[7:0];
                end
            end
            10'd16: begin
                for (int e = 0; e < N16; e++) begin
                    lane_t = mul_step({16'd0, acc_q[e*16 +: 16]}, {16'd0, a_q[e*16 +: 16]},
                                      b_q[e*16 + 15], first);
                    mul_nx[e*16 +: 16] = lane_t[15:0];
                    lane_t = lane_addsub({16'd0, a_q[e*16 +: 16]}, {16'd0, b_q[e*16 +: 16]}, is_sub, 16);
                    addsub_res[e*16 +: 16] = lane_t[15:0];
                    lane_t = lane_addsub({16'd0, acc_q[e*16 +: 16]}, {16'd0, c_q[e*16 +: 16]}, 1'b0, 16);
                    macc_res[e*16 +: 16] = lane_t[15:0];
                end
            end
            10'd32: begin
                for (int e = 0; e < N32; e++) begin
                    lane_t = mul_step(acc_q[e*32 +: 32], a_q[e*32 +: 32], b_q[e*32 + 31], first);
                    mul_nx[e*32 +: 32] = lane_t;
                    lane_t = lane_addsub(a_q[e*32 +: 32], b_q[e*32 +: 32], is_sub, 32);
                    addsub_res[e*32 +: 32] = lane_t;
                    lane_t = lane_addsub(acc_q[e*32 +: 32], c_q[e*32 +: 32], 1'b0, 32);
                    macc_res[e*32 +: 32] = lane_t;
                end
            end
            default: ;
        endcase
    end

    // Next-state and register-update logic for the IDLE/MUL/COMPLETE sequencer.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sew_d   = sew_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        acc_d   = acc_q;
        peout_d = peout_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d  = bus.op;
                    sew_d = bus.sew;
                    a_d   = bus.opA;
                    b_d   = bus.opB;
                    c_d   = bus.opC;
                    err_d = 1'b0;
                    if (legal_op(bus.op) && legal_sew(bus.sew) &&
                        ((bus.op == OP_MUL) || (bus.op == OP_MACC))) begin
                        cnt_d   = bus.sew[5:0];
                        state_d = S_MUL;
                    end else begin
                        state_d = S_COMPLETE;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_nx;
                // A whole-word shift is safe: bits leaving one lane would need a
                // full SEW further shifts to reach the next lane's sampled MSB.
                b_d   = b_q << 1;
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) state_d = S_COMPLETE;
            end
            S_COMPLETE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (!legal_op(op_q) || !legal_sew(sew_q)) begin
                    peout_d = '0;
                    err_d   = 1'b1;
                end else begin
                    case (op_q)
                        OP_ADD, OP_SUB: peout_d = addsub_res;
                        OP_MUL:         peout_d = acc_q;
                        default:        peout_d = macc_res;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything and aborts any operation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            sew_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            acc_q   <= '0;
            peout_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sew_q   <= sew_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            peout_q <= peout_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_vector_pe_multi.sv
// tb_vector_pe_multi: self-checking bench for vector_pe_multi (DATA_W=32) with a
// lane-level arithmetic reference model. Honours VPE_SATURATE_EN when defined.
module tb_vector_pe_multi;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    vector_pe_multi_if #(.DATA_W(32), .OP_W(3)) bus ();

    vector_pe_multi #(.DATA_W(32), .OP_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Signed value of element e (width w) of a packed word.
    function automatic longint lane_s(input logic [31:0] x, input int e, input int w);
        longint v;
        v = (longint'(x) >> (e * w)) & ((longint'(1) << w) - 1);
        if (v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
        return v;
    endfunction

    // Reinterpret the low w bits of r as a signed value.
    function automatic longint wrap_s(input longint r, input int w);
        longint v;
        v = r & ((longint'(1) << w) - 1);
        if (v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
        return v;
    endfunction

    // Reference: whole-operation result computed element by element.
    function automatic logic [31:0] model(input int op, input int sew,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, output logic err);
        logic [31:0] res;
        res = 32'd0;
        if (!(sew == 8 || sew == 16 || sew == 32) || op > 3) begin
            err = 1'b1;
            return 32'd0;
        end
        err = 1'b0;
        for (int e = 0; e < 32 / sew; e++) begin
            longint sa, sb, sc, r, hi, lo;
            sa = lane_s(a, e, sew);
            sb = lane_s(b, e, sew);
            sc = lane_s(c, e, sew);
            case (op)
                0:       r = sa + sb;
                1:       r = sa - sb;
                2:       r = sa * sb;
                default: r = wrap_s(sa * sb, sew) + sc;
            endcase
`ifdef VPE_SATURATE_EN
            hi = (longint'(1) << (sew - 1)) - 1;
            lo = -(longint'(1) << (sew - 1));
            if (op != 2) begin
                if (r > hi) r = hi;
                else if (r < lo) r = lo;
            end
`else
            hi = 0;
            lo = 0;
`endif
            res = res | 32'((r & ((longint'(1) << sew) - 1)) << (e * sew));
        end
        return res;
    endfunction

    // Issue one operation and wait (bounded) for done; inputs are scrambled after the start edge.
    task automatic run_op(input logic [2:0] op, input logic [9:0] sew,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          output logic [31:0] res, output logic e_o,
                          output int lat, output int busy_cyc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.sew   = sew;
        bus.opA   = a;
        bus.opB   = b;
        bus.opC   = c;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.opA   = $urandom;
        bus.opB   = $urandom;
        bus.opC   = $urandom;
        bus.op    = 3'($urandom);
        bus.sew   = 10'($urandom);
        lat = 0;
        busy_cyc = 0;
        res = 32'd0;
        e_o = 1'b0;
        while (lat < 100) begin
            if (bus.busy) busy_cyc++;
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) begin
                res = bus.peout;
                e_o = bus.err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.sew = 10'd8;
        bus.opA = 32'd0;
        bus.opB = 32'd0;
        bus.opC = 32'd0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", bus.err); end
        checks++; if (bus.peout !== 32'd0) begin errors++; $display("FAIL reset_peout got=%h exp=0", bus.peout); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_add;
        logic [31:0] res, exp;
        logic e, ee;
        int lat, bc;
`ifdef VPE_SATURATE_EN
        exp = 32'h7F020081;
`else
        exp = 32'h80020081;
`endif
        run_op(3'd0, 10'd8, 32'h7F01FF80, 32'h01010101, 32'd0, res, e, lat, bc);
        checks++; if (res !== exp) begin errors++; $display("FAIL add8_peout got=%h exp=%h", res, exp); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL add8_err got=%0b exp=0", e); end
        checks++; if (lat != 1) begin errors++; $display("FAIL add8_latency got=%0d exp=1", lat); end
        @(posedge clk);
        #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL add8_done_pulse got=%0b exp=0", bus.done); end
        checks++; if (bus.peout !== exp) begin errors++; $display("FAIL add8_hold got=%h exp=%h", bus.peout, exp); end
        ee = 1'b0;
        exp = model(0, 8, 32'h7F01FF80, 32'h01010101, 32'd0, ee);
        checks++; if (res !== exp) begin errors++; $display("FAIL add8_model got=%h exp=%h", res, exp); end
    endtask

    task automatic test_mul;
        logic [31:0] res;
        logic e;
        int lat, bc;
        run_op(3'd2, 10'd16, 32'hFFFD0007, 32'h0004FFFE, 32'd0, res, e, lat, bc);
        checks++; if (res !== 32'hFFF4FFF2) begin errors++; $display("FAIL mul16_peout got=%h exp=fff4fff2", res); end
        checks++; if (lat != 17) begin errors++; $display("FAIL mul16_latency got=%0d exp=17", lat); end
        checks++; if (bc != 17) begin errors++; $display("FAIL mul16_busy_cycles got=%0d exp=17", bc); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL mul16_err got=%0b exp=0", e); end
    endtask

    task automatic test_macc;
        logic [31:0] res;
        logic e;
        int lat, bc;
        run_op(3'd3, 10'd32, 32'd6, 32'hFFFFFFF9, 32'd50, res, e, lat, bc);
        checks++; if (res !== 32'h00000008) begin errors++; $display("FAIL macc32_peout got=%h exp=00000008", res); end
        checks++; if (lat != 33) begin errors++; $display("FAIL macc32_latency got=%0d exp=33", lat); end
    endtask

    task automatic test_random;
        int sews[3] = '{8, 16, 32};
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, b, c, res, exp;
            logic e, ee;
            int op, sew, lat, bc, elat;
            a = $urandom;
            b = $urandom;
            c = $urandom;
            op = $urandom_range(0, 3);
            sew = sews[$urandom_range(0, 2)];
            if ($urandom_range(0, 9) == 0) op = $urandom_range(4, 7);
            if ($urandom_range(0, 9) == 0) sew = $urandom_range(0, 63);
            ee = 1'b0;
            exp = model(op, sew, a, b, c, ee);
            elat = (ee || op < 2) ? 1 : sew + 1;
            run_op(3'(op), 10'(sew), a, b, c, res, e, lat, bc);
            checks++; if (res !== exp) begin errors++; $display("FAIL rand%0d_peout op=%0d sew=%0d got=%h exp=%h", i, op, sew, res, exp); end
            checks++; if (e !== ee) begin errors++; $display("FAIL rand%0d_err got=%0b exp=%0b", i, e, ee); end
            checks++; if (lat != elat) begin errors++; $display("FAIL rand%0d_latency got=%0d exp=%0d", i, lat, elat); end
        end
    endtask

    task automatic test_start_while_busy;
        logic [31:0] a, b, got, exp, res;
        logic ee, e;
        int dones, lat, bc;
        a = $urandom;
        b = $urandom;
        ee = 1'b0;
        exp = model(2, 8, a, b, 32'd0, ee);
        got = 32'd0;
        dones = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 3'd2;
        bus.sew = 10'd8;
        bus.opA = a;
        bus.opB = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            bus.start = (k == 3);
            if (k == 3) begin
                bus.op = 3'd0;
                bus.opA = 32'h02020202;
                bus.opB = 32'h02020202;
            end
            @(posedge clk);
            #1;
            if (bus.done) begin
                dones++;
                got = bus.peout;
            end
        end
        bus.start = 1'b0;
        checks++; if (dones != 1) begin errors++; $display("FAIL busy_start_dones got=%0d exp=1", dones); end
        checks++; if (got !== exp) begin errors++; $display("FAIL busy_start_peout got=%h exp=%h", got, exp); end
        exp = model(0, 16, 32'h12345678, 32'h11111111, 32'd0, ee);
        run_op(3'd0, 10'd16, 32'h12345678, 32'h11111111, 32'd0, res, e, lat, bc);
        checks++; if (res !== exp) begin errors++; $display("FAIL busy_start_next got=%h exp=%h", res, exp); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] res;
        logic e;
        int lat, bc, dones;
        dones = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 3'd2;
        bus.sew = 10'd8;
        bus.opA = 32'h05050505;
        bus.opB = 32'h03030303;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.peout !== 32'd0) begin errors++; $display("FAIL rstmid_peout got=%h exp=0", bus.peout); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%0b exp=0", bus.done); end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=0", dones); end
        run_op(3'd1, 10'd32, 32'd5, 32'd9, 32'd0, res, e, lat, bc);
        checks++; if (res !== 32'hFFFFFFFC) begin errors++; $display("FAIL rstmid_sub got=%h exp=fffffffc", res); end
    endtask

    task automatic test_illegal;
        logic [31:0] res;
        logic e;
        int lat, bc;
        run_op(3'd0, 10'd12, 32'h11223344, 32'h01010101, 32'd0, res, e, lat, bc);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL ill_sew_err got=%0b exp=1", e); end
        checks++; if (res !== 32'd0) begin errors++; $display("FAIL ill_sew_peout got=%h exp=0", res); end
        checks++; if (lat != 1) begin errors++; $display("FAIL ill_sew_latency got=%0d exp=1", lat); end
        run_op(3'd5, 10'd8, 32'h11223344, 32'h01010101, 32'd0, res, e, lat, bc);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL ill_op_err got=%0b exp=1", e); end
        checks++; if (res !== 32'd0) begin errors++; $display("FAIL ill_op_peout got=%h exp=0", res); end
        checks++; if (lat != 1) begin errors++; $display("FAIL ill_op_latency got=%0d exp=1", lat); end
        run_op(3'd0, 10'd8, 32'h01020304, 32'h01010101, 32'd0, res, e, lat, bc);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL ill_clear_err got=%0b exp=0", e); end
        checks++; if (res !== 32'h02030405) begin errors++; $display("FAIL ill_clear_peout got=%h exp=02030405", res); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r1, r2, x1, x2;
        logic e1, e2, ee;
        int l1, l2, b1, b2;
        ee = 1'b0;
        x1 = model(3, 16, 32'h00030004, 32'h00050006, 32'h00010001, ee);
        x2 = model(1, 8, 32'h10203040, 32'h01020304, 32'd0, ee);
        run_op(3'd3, 10'd16, 32'h00030004, 32'h00050006, 32'h00010001, r1, e1, l1, b1);
        run_op(3'd1, 10'd8, 32'h10203040, 32'h01020304, 32'd0, r2, e2, l2, b2);
        checks++; if (r1 !== x1) begin errors++; $display("FAIL b2b_first got=%h exp=%h", r1, x1); end
        checks++; if (r2 !== x2) begin errors++; $display("FAIL b2b_second got=%h exp=%h", r2, x2); end
        checks++; if (l2 != 1) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=1", l2); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_macc();
        test_start_while_busy();
        test_reset_mid();
        test_illegal();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
